dds_dac_packer: RTL

Downstream companion of the single-channel DDS. It paces the DDS pipeline by issuing `dreq_o` and captures each output sample one cycle later. It discards the priming samples after start and packs consecutive samples into wide DAC words. Packed words are buffered in a small FIFO and presented to the DAC/serializer on a valid/ready interface, with sticky underrun reporting.

---
 rtl/dds_pkg.sv | 17 +
 rtl/dds_dac_packer_if.sv | 14 +
 rtl/dds_packer_fifo.sv | 55 +++++
 rtl/dds_dac_packer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS output path: pipeline depth, packer states
// and the packed-word width helper.
package dds_pkg;

  localparam int c_dds_pipe_depth = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } t_packer_state;

  function automatic int packed_width(input int sample_bits, input int samples_per_word);
    return sample_bits * samples_per_word;
  endfunction

endpackage

// File: rtl/dds_dac_packer_if.sv
// Valid/ready stream carrying packed DAC words from the packer to the
// DAC/serializer; the packer is the master.
interface dds_dac_packer_if #(
  parameter int g_width = 48
) ();

  logic [g_width-1:0] data;
  logic               valid;
  logic               ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/dds_packer_fifo.sv
// Synchronous first-word fall-through FIFO; head reads as zero while empty.
module dds_packer_fifo #(
  parameter int g_width      = 48,
  parameter int g_depth_log2 = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push,
  input  logic                    pop,
  input  logic [g_width-1:0]      wdata,
  output logic [g_width-1:0]      head,
  output logic                    empty,
  output logic                    full,
  output logic [g_depth_log2:0]   level
);

  localparam int c_depth = 1 << g_depth_log2;
  localparam logic [g_depth_log2-1:0] c_ptr_one   = 1;
  localparam logic [g_depth_log2:0]   c_level_one = 1;
  localparam logic [g_depth_log2:0]   c_level_max = (g_depth_log2 + 1)'(c_depth);

  logic [g_width-1:0]      mem [c_depth];
  logic [g_depth_log2-1:0] wr_ptr;
  logic [g_depth_log2-1:0] rd_ptr;
  logic                    do_push;
  logic                    do_pop;

  assign empty   = (level == '0);
  assign full    = (level == c_level_max);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and level do, and head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + c_ptr_one;
      if (do_pop)  rd_ptr <= rd_ptr + c_ptr_one;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + c_level_one;
        2'b01:   level <= level - c_level_one;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dds_dac_packer.sv
// Paces the DDS with dreq pulses, drops priming samples, packs samples into
// DAC words and streams them out of a FIFO. Define DDS_PACKER_OFFSET_BINARY_EN
// to convert samples to offset binary before packing.
module dds_dac_packer
  import dds_pkg::*;
#(
  parameter int g_output_bits      = 12,
  parameter int g_samples_per_word = 4,
  parameter int g_fifo_depth_log2  = 4,
  parameter int g_prime_samples    = c_dds_pipe_depth
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic [g_output_bits-1:0]     y_i,
  output logic                         dreq_o,
  input  logic                         clr_i,
  output logic                         underrun_o,
  output logic [g_fifo_depth_log2:0]   level_o,
  dds_dac_packer_if.master             dac
);

  localparam int c_word_bits  = packed_width(g_output_bits, g_samples_per_word);
  localparam int c_lane_bits  = (g_samples_per_word > 1) ? $clog2(g_samples_per_word) : 1;
  localparam int c_prime_bits = $clog2(g_prime_samples + 1);
  localparam logic [c_lane_bits-1:0]  c_lane_one  = 1;
  localparam logic [c_lane_bits-1:0]  c_last_lane = c_lane_bits'(g_samples_per_word - 1);
  localparam logic [c_prime_bits-1:0] c_prime_one = 1;
  localparam logic [c_prime_bits-1:0] c_last_prime = c_prime_bits'(g_prime_samples - 1);
  // Two free entries are required before a run-time dreq is issued.
  localparam logic [g_fifo_depth_log2:0] c_dreq_max_level =
    (g_fifo_depth_log2 + 1)'((1 << g_fifo_depth_log2) - 2);

  t_packer_state            state, state_nxt;
  logic                     enable_q;
  logic                     dreq_q;
  logic                     dreq_run_q;
  logic [c_lane_bits-1:0]   lane_q;
  logic [c_prime_bits-1:0]  prime_q;
  logic [c_word_bits-1:0]   word_q, word_nxt;
  logic                     pushed_q;
  logic [g_output_bits-1:0] sample;
  logic                     start, prime_cap, run_cap, fifo_push;
  logic                     fifo_empty, fifo_full, underrun_set;
  logic [c_word_bits-1:0]   fifo_head;

`ifdef DDS_PACKER_OFFSET_BINARY_EN
  assign sample = y_i ^ {1'b1, {(g_output_bits - 1){1'b0}}};
`else
  assign sample = y_i;
`endif

  assign start     = (state == IDLE) && enable_i && !enable_q;
  assign prime_cap = dreq_q && !dreq_run_q && (state == PRIME);
  // A capture belongs to the state its dreq was issued in, even after enable drops.
  assign run_cap   = dreq_q && dreq_run_q && !start;
  assign fifo_push = run_cap && (lane_q == c_last_lane);

  assign underrun_set = dac.ready && fifo_empty && (state == RUN) && pushed_q;
  assign dac.valid    = !fifo_empty;
  assign dac.data     = fifo_head;

  always_comb begin
    word_nxt = word_q;
    word_nxt[lane_q * g_output_bits +: g_output_bits] = sample;
  end

  // NOTE: every output of a combinational block is defaulted first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    dreq_o    = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = PRIME;
      PRIME: begin
        dreq_o = !dreq_q;
        if (!enable_i) state_nxt = IDLE;
        else if (prime_cap && prime_q == c_last_prime) state_nxt = RUN;
      end
      RUN: begin
        dreq_o = !dreq_q && (level_o <= c_dreq_max_level);
        if (!enable_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      enable_q   <= 1'b0;
      dreq_q     <= 1'b0;
      dreq_run_q <= 1'b0;
      lane_q     <= '0;
      prime_q    <= '0;
      word_q     <= '0;
      pushed_q   <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      enable_q   <= enable_i;
      dreq_q     <= dreq_o;
      dreq_run_q <= (state == RUN);
      if (start) begin
        lane_q   <= '0;
        prime_q  <= '0;
        pushed_q <= 1'b0;
      end else begin
        if (prime_cap) prime_q <= prime_q + c_prime_one;
        if (run_cap) begin
          word_q <= word_nxt;
          lane_q <= (lane_q == c_last_lane) ? '0 : lane_q + c_lane_one;
        end
        if (fifo_push) pushed_q <= 1'b1;
      end
      if (underrun_set)  underrun_o <= 1'b1;
      else if (clr_i)    underrun_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && fifo_push) assert (!fifo_full);
  end

  dds_packer_fifo #(
    .g_width      (c_word_bits),
    .g_depth_log2 (g_fifo_depth_log2)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .pop   (!fifo_empty && dac.ready),
    .wdata (word_nxt),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level_o)
  );

endmodule
